// File: rtl/mdu_iter_if.sv
// Multiply/divide unit request/response bundle: command fields in, status and HI/LO out.
// Pure wiring, no latency of its own.
// The master must hold off commands while busy; commands issued during busy are dropped.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues commands, reads status and HI/LO.
  modport master (
    output start, md_op, srcA, srcB,
    input  busy, done, hi, lo
  );

  // MDU side: consumes commands, owns status and HI/LO.
  modport slave (
    input  start, md_op, srcA, srcB,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO; optional madd/msub under MDU_MADD_EN.
// Latency: mult MUL_CYCLES, div WIDTH, div-by-zero 1 cycle, mthi/mtlo immediate; done pulses after commit.
// No queueing: start is accepted only while busy=0, otherwise ignored; EX stalls on busy|start.
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input logic     clk,
  input logic     reset,
  mdu_iter_if.slave md
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic               div_zero;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH-1:0]   dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
`ifdef MDU_MADD_EN
  logic               acc_add;
  logic               acc_sub;
`endif

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   q_next;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  // Operand conditioning for launch and one restoring-division step for the running divide.
  always_comb begin
    op_signed = (md.md_op == OP_MULT) || (md.md_op == OP_DIV);
`ifdef MDU_MADD_EN
    if ((md.md_op == OP_MADD) || (md.md_op == OP_MSUB)) op_signed = 1'b1;
`endif
    a_neg     = op_signed & md.srcA[WIDTH-1];
    b_neg     = op_signed & md.srcB[WIDTH-1];
    // Sign-extended 2W x 2W product truncated to 2W is the exact signed product.
    a_ext     = {{WIDTH{a_neg}}, md.srcA};
    b_ext     = {{WIDTH{b_neg}}, md.srcB};
    prod_next = a_ext * b_ext;
    // Negating MIN yields MIN, which read unsigned is the correct magnitude.
    a_mag     = a_neg ? -md.srcA : md.srcA;
    b_mag     = b_neg ? -md.srcB : md.srcB;

    shifted   = {rem, dvd[WIDTH-1]};
    diff      = shifted - {1'b0, dvs};
    fits      = ~diff[WIDTH];
    rem_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_next    = {dvd[WIDTH-2:0], fits};
    quot_fix  = q_neg ? -q_next : q_next;
    rem_fix   = r_neg ? -rem_next : rem_next;
  end

  // Control FSM, datapath registers and HI/LO commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prod     <= '0;
      div_zero <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_MADD_EN
      acc_add  <= 1'b0;
      acc_sub  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (md.start) begin
            case (md.md_op)
              OP_MULT, OP_MULTU: begin
                prod   <= prod_next;
                cnt    <= CNT_W'(MUL_CYCLES - 1);
                state  <= MUL;
                busy_q <= 1'b1;
`ifdef MDU_MADD_EN
                acc_add <= 1'b0;
                acc_sub <= 1'b0;
`endif
              end
`ifdef MDU_MADD_EN
              OP_MADD, OP_MSUB: begin
                prod    <= prod_next;
                cnt     <= CNT_W'(MUL_CYCLES - 1);
                state   <= MUL;
                busy_q  <= 1'b1;
                acc_add <= (md.md_op == OP_MADD);
                acc_sub <= (md.md_op == OP_MSUB);
              end
`endif
              OP_DIV, OP_DIVU: begin
                state    <= DIV;
                busy_q   <= 1'b1;
                div_zero <= (md.srcB == '0);
                dvd      <= a_mag;
                dvs      <= b_mag;
                rem      <= '0;
                q_neg    <= a_neg ^ b_neg;
                r_neg    <= a_neg;
                cnt      <= CNT_W'(WIDTH - 1);
              end
              OP_MTHI: hi_q <= md.srcA;
              OP_MTLO: lo_q <= md.srcA;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt == '0) begin
`ifdef MDU_MADD_EN
            if (acc_add)      {hi_q, lo_q} <= {hi_q, lo_q} + prod;
            else if (acc_sub) {hi_q, lo_q} <= {hi_q, lo_q} - prod;
            else              {hi_q, lo_q} <= prod;
`else
            {hi_q, lo_q} <= prod;
`endif
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIV: begin
          if (div_zero) begin
            // Divide by zero leaves HI/LO as they were and just retires.
            div_zero <= 1'b0;
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            dvd <= q_next;
            rem <= rem_next;
            if (cnt == '0) begin
              lo_q   <= quot_fix;
              hi_q   <= rem_fix;
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: mult/div results, latencies, done pulse, ignored start, async abort.
// Inputs change and outputs are sampled on the falling clock edge.
// Every wait on busy is bounded by a cycle budget.
module tb_mdu_iter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_iter_if #(.WIDTH(32)) md ();

  mdu_iter #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a command for exactly one rising edge; returns on the falling edge after it.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md.start = 1'b1;
    md.md_op = op;
    md.srcA  = a;
    md.srcB  = b;
    @(negedge clk);
    md.start = 1'b0;
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    launch(op, a, b);
    while (md.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy"}, 64'(n), 64'(exp_busy));
    check({tag, "_done"}, 64'(md.done), 64'd1);
    check({tag, "_hi"}, 64'(md.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(md.lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, "_done_once"}, 64'(md.done), 64'd0);
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] a);
    launch(op, a, 32'h0);
    check({tag, "_busy"}, 64'(md.busy), 64'd0);
    check({tag, "_done"}, 64'(md.done), 64'd0);
  endtask

  initial begin
    int n;
    clk      = 1'b0;
    reset    = 1'b0;
    checks   = 0;
    failures = 0;
    md.start = 1'b0;
    md.md_op = 3'd0;
    md.srcA  = 32'h0;
    md.srcB  = 32'h0;

    #2;
    check("rst_busy", 64'(md.busy), 64'd0);
    check("rst_done", 64'(md.done), 64'd0);
    check("rst_hi", 64'(md.hi), 64'd0);
    check("rst_lo", 64'(md.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_md("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00000005, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_md("multu", 3'd1, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE);
    run_md("div_neg", 3'd2, 32'hFFFFFFF9, 32'h00000002, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu", 3'd3, 32'h00000064, 32'h00000007, 32, 32'h00000002, 32'h0000000E);
    run_md("div_negdvs", 3'd2, 32'h00000007, 32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD);
    run_md("div_min", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, 32'h80000000);
    run_md("divu_big", 3'd3, 32'hFFFFFFFF, 32'h00000010, 32, 32'h0000000F, 32'h0FFFFFFF);

    move_to("mthi", 3'd4, 32'h12345678);
    check("mthi_hi", 64'(md.hi), 64'h12345678);
    move_to("mtlo", 3'd5, 32'h9ABCDEF0);
    check("mtlo_lo", 64'(md.lo), 64'h9ABCDEF0);
    run_md("div0", 3'd2, 32'h00000005, 32'h00000000, 1, 32'h12345678, 32'h9ABCDEF0);

    // A mult request arriving mid-divide must be dropped without trace.
    n = 0;
    launch(3'd3, 32'h00000064, 32'h00000007);
    while (md.busy && n < 200) begin
      n++;
      if (n == 10) begin
        md.start = 1'b1;
        md.md_op = 3'd0;
        md.srcA  = 32'h2;
        md.srcB  = 32'h3;
      end else begin
        md.start = 1'b0;
      end
      @(negedge clk);
    end
    md.start = 1'b0;
    check("ign_busy", 64'(n), 64'd32);
    check("ign_hi", 64'(md.hi), 64'h2);
    check("ign_lo", 64'(md.lo), 64'hE);
    @(negedge clk);
    check("ign_no_relaunch", 64'(md.busy), 64'd0);

    // Back-to-back: a new start in the done cycle launches while done still marks the old op.
    n = 0;
    launch(3'd1, 32'h2, 32'h3);
    while (md.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("b2b_done_old", 64'(md.done), 64'd1);
    md.start = 1'b1;
    md.md_op = 3'd1;
    md.srcA  = 32'h4;
    md.srcB  = 32'h5;
    @(negedge clk);
    md.start = 1'b0;
    check("b2b_busy_new", 64'(md.busy), 64'd1);
    n = 0;
    while (md.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("b2b_lat", 64'(n), 64'd5);
    check("b2b_lo", 64'(md.lo), 64'd20);

    // Asynchronous abort in the middle of a divide.
    n = 0;
    launch(3'd2, 32'hFFFFFFF9, 32'h00000002);
    while (md.busy && n < 15) begin
      n++;
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(md.busy), 64'd0);
    check("abort_hi", 64'(md.hi), 64'd0);
    check("abort_lo", 64'(md.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md.done || md.busy) n++;
    end
    check("abort_no_done", 64'(n), 64'd0);

`ifdef MDU_MADD_EN
    move_to("madd_mthi", 3'd4, 32'h0);
    move_to("madd_mtlo", 3'd5, 32'd10);
    run_md("madd", 3'd6, 32'd3, 32'd4, 5, 32'h0, 32'h00000016);
    run_md("msub", 3'd7, 32'd2, 32'd3, 5, 32'h0, 32'h00000010);
    run_md("msub_neg", 3'd7, 32'd5, 32'd4, 5, 32'hFFFFFFFF, 32'hFFFFFFFC);
    run_md("madd_sgn", 3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
    move_to("op6_nop", 3'd6, 32'h5);
    check("op6_hi", 64'(md.hi), 64'h0);
    check("op6_lo", 64'(md.lo), 64'h0);
    move_to("op7_nop", 3'd7, 32'h5);
    check("op7_lo", 64'(md.lo), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
